matmul_pcpi_sequencer: RTL
==========================

// Module: matmul_pcpi_sequencer
// PURPOSE
//  Host-side command sequencer for the 3x3 fused matrix-mult PCPI coprocessor (custom opcode 0001011).
//  Holds a 28-entry shadow operand file (A 0-8, B 9-17, bias 18-26, threshold 27).
//  On start: issues one load insn per dirty entry, then compute, then clear. Captures pcpi_rd.
//  Sits between the control-register bus and the coprocessor's PCPI port, replacing CPU-driven load loops.
// PARAMETERS
//  FULL_RELOAD  0    1: treat every entry as dirty on every job.
//  TIMEOUT      64   Max cycles spent in any *_WAIT state before abort (>=16).
//  THRESH_RST   -70  Reset value of shadow entry 27 (signed 16b).
// PORTS
//  clk         in   1   Single clock, rising edge.
//  rst         in   1   Asynchronous, active-high reset.
//  cfg_we      in   1   Shadow write strobe.
//  cfg_addr    in   5   Shadow index 0-27; 28-31 ignored.
//  cfg_wdata   in   16  Signed operand value.
//  cfg_drop    out  1   1-cycle pulse: write discarded (busy or addr>27).
//  start       in   1   1-cycle job request; ignored while busy.
//  busy        out  1   Job in progress.
//  done        out  1   1-cycle pulse at job end.
//  err         out  1   Sticky timeout flag; cleared by next accepted start.
//  result      out  32  pcpi_rd captured at compute completion.
//  pcpi_valid  out  1   Insn strobe to coprocessor.
//  pcpi_insn   out  32  {1'b0, value[15:0], funct3[2:0], addr[4:0], 7'b0001011}.
//  pcpi_ready  in   1   Coprocessor ready.
//  pcpi_wait   in   1   Coprocessor busy (status only; recorded, not required for flow).
//  pcpi_rd     in   32  Coprocessor result.
// BEHAVIOUR
//  Reset (async, any state): IDLE; busy=done=err=cfg_drop=pcpi_valid=0; result=0; pcpi_insn=0.
//   Shadow entries 0-26 = 0; entry 27 = THRESH_RST; all 28 dirty bits set.
//  Shadow write: in IDLE, cfg_we with addr<=27 stores data and sets dirty[addr] at the clock edge.
//   Otherwise cfg_drop pulses the next cycle.
//   cfg_we and start in the same IDLE cycle: the write is included in the job.
//  All outputs are registered. pcpi_valid is high for exactly one cycle per insn; pcpi_insn is held stable from that cycle until the next issue.
//  States: IDLE -> SCAN -> L_ISSUE -> L_WAIT -> SCAN ... -> C_ISSUE -> C_SETTLE -> C_WAIT -> K_ISSUE -> K_WAIT -> DONE -> IDLE.
//  IDLE: start -> SCAN with ptr=0; busy=1 from next cycle.
//  SCAN: one cycle per entry.
//   dirty[ptr] (or FULL_RELOAD) -> L_ISSUE.
//   Else, if ptr==27 -> C_ISSUE; else ptr+1.
//  L_ISSUE: valid=1, funct3=000, addr=ptr, value=shadow[ptr] -> L_WAIT.
//  L_WAIT: pcpi_ready ignored in the first cycle after issue (turnaround).
//   First later cycle with pcpi_ready=1: clear dirty[ptr]. Then ptr==27 -> C_ISSUE, else ptr+1 -> SCAN.
//  C_ISSUE: valid=1, funct3=111, addr=0, value=0 -> C_SETTLE (1 cycle, ready ignored) -> C_WAIT.
//  C_WAIT: first cycle with pcpi_ready=1: result<=pcpi_rd -> K_ISSUE.
//  K_ISSUE: valid=1, funct3=101 (release) -> K_WAIT.
//   Same turnaround rule as L_WAIT; pcpi_ready=1 -> DONE.
//  DONE: done=1 for one cycle, busy drops in the same cycle -> IDLE.
//  Timeout: wait counter resets on entry to each *_WAIT state.
//   Reaching TIMEOUT in L_WAIT or C_WAIT sets err and jumps to K_ISSUE; result is unchanged; dirty bits are untouched.
//   Timeout in K_WAIT sets err and goes to DONE.
//  Clean job (FULL_RELOAD=0, no dirty): start@T -> SCAN T+1..T+28 -> C_ISSUE T+29.
//  Reset mid-job: immediate IDLE. Dirty bits return to all-set, so the next job performs a full reload.
// TESTING
//  1. Post-reset start, ideal model (ready 1 cycle after each load/clear, 8 cycles after compute):
//     -> 28 loads in addr order 0..27, entry 27 value 0xFFBA, then 111, then 101. done once; busy low after.
//  2. Write addr 4=0x0007, start; all other entries clean -> exactly one load insn 0x0003820B (value 7, addr 4, funct3 000), then compute and clear.
//  3. Model returns pcpi_rd=0x1234_5678 at compute ready -> result=0x12345678 after done; err=0.
//  4. Hold pcpi_ready=0 after compute (TIMEOUT=64) -> after 64 C_WAIT cycles err=1, a 101 insn is issued, done pulses.
//     The next start clears err.
//  5. cfg_we while busy and cfg_we at addr 30 in IDLE -> cfg_drop pulses and shadow is unchanged.
//     start while busy -> no second job.
//  6. Assert rst during L_WAIT of entry 10 -> all outputs 0 immediately.
//     The next start reloads all 28 entries.

Source files
------------

// File: rtl/matmul_pcpi_sequencer.sv
// Host-side command sequencer for the 3x3 matrix-mult PCPI coprocessor: replays dirty
// shadow operands as load insns, then issues compute and release, capturing the result.
module matmul_pcpi_sequencer #(
  parameter bit                 FULL_RELOAD = 1'b0,
  parameter int                 TIMEOUT     = 64,
  parameter logic signed [15:0] THRESH_RST  = -16'sd70
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [4:0]         cfg_addr,
  input  logic signed [15:0] cfg_wdata,
  output logic               cfg_drop,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        result,
  output logic               pcpi_valid,
  output logic [31:0]        pcpi_insn,
  input  logic               pcpi_ready,
  input  logic               pcpi_wait,
  input  logic [31:0]        pcpi_rd
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SCAN   = 4'd1;
  localparam logic [3:0] S_LISS   = 4'd2;
  localparam logic [3:0] S_LWAIT  = 4'd3;
  localparam logic [3:0] S_CISS   = 4'd4;
  localparam logic [3:0] S_CSET   = 4'd5;
  localparam logic [3:0] S_CWAIT  = 4'd6;
  localparam logic [3:0] S_KISS   = 4'd7;
  localparam logic [3:0] S_KWAIT  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [6:0]  OPC      = 7'b0001011;
  localparam logic [4:0]  LAST_IDX = 5'd27;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [3:0]         state_q, state_d;
  logic [4:0]         ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [27:0]        dirty_q;
  logic signed [15:0] shadow_q [0:27];
  logic               busy_q, done_q, err_q, drop_q, valid_q;
  logic [31:0]        result_q, insn_q;
  logic               wait_seen_unused_q;
  logic               clr_dirty, set_err, cap_res, wr_ok, job_go;

  assign wr_ok  = (state_q == S_IDLE) && cfg_we && (cfg_addr <= LAST_IDX);
  assign job_go = (state_q == S_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    clr_dirty = 1'b0;
    set_err   = 1'b0;
    cap_res   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          ptr_d   = 5'd0;
        end
      end
      S_SCAN: begin
        if (dirty_q[ptr_q] || FULL_RELOAD) state_d = S_LISS;
        else if (ptr_q == LAST_IDX)        state_d = S_CISS;
        else                               ptr_d   = ptr_q + 5'd1;
      end
      S_LISS: begin
        state_d = S_LWAIT;
        cnt_d   = '0;
      end
      // First wait cycle after an issue is turnaround; ready is not sampled there.
      S_LWAIT: begin
        cnt_d = cnt_q + 16'd1;
        if ((cnt_q != 16'd0) && pcpi_ready) begin
          clr_dirty = 1'b1;
          if (ptr_q == LAST_IDX) state_d = S_CISS;
          else begin
            state_d = S_SCAN;
            ptr_d   = ptr_q + 5'd1;
          end
        end else if (cnt_q == TMO_LAST) begin
          set_err = 1'b1;
          state_d = S_KISS;
        end
      end
      S_CISS: state_d = S_CSET;
      S_CSET: begin
        state_d = S_CWAIT;
        cnt_d   = '0;
      end
      S_CWAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (pcpi_ready) begin
          cap_res = 1'b1;
          state_d = S_KISS;
        end else if (cnt_q == TMO_LAST) begin
          set_err = 1'b1;
          state_d = S_KISS;
        end
      end
      S_KISS: begin
        state_d = S_KWAIT;
        cnt_d   = '0;
      end
      S_KWAIT: begin
        cnt_d = cnt_q + 16'd1;
        if ((cnt_q != 16'd0) && pcpi_ready) begin
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      ptr_q              <= '0;
      cnt_q              <= '0;
      dirty_q            <= '1;
      for (int i = 0; i < 27; i++) shadow_q[i] <= '0;
      shadow_q[27]       <= THRESH_RST;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      err_q              <= 1'b0;
      drop_q             <= 1'b0;
      valid_q            <= 1'b0;
      result_q           <= '0;
      insn_q             <= '0;
      wait_seen_unused_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      drop_q  <= cfg_we && !wr_ok;
      valid_q <= (state_d == S_LISS) || (state_d == S_CISS) || (state_d == S_KISS);
      if (wr_ok) begin
        shadow_q[cfg_addr] <= cfg_wdata;
        dirty_q[cfg_addr]  <= 1'b1;
      end
      if (clr_dirty) dirty_q[ptr_q] <= 1'b0;
      if (job_go)       err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
      if (cap_res) result_q <= pcpi_rd;
      if (state_d == S_LISS)      insn_q <= {1'b0, shadow_q[ptr_d], 3'b000, ptr_d, OPC};
      else if (state_d == S_CISS) insn_q <= {1'b0, 16'h0000, 3'b111, 5'd0, OPC};
      else if (state_d == S_KISS) insn_q <= {1'b0, 16'h0000, 3'b101, 5'd0, OPC};
      if (job_go)         wait_seen_unused_q <= 1'b0;
      else if (pcpi_wait) wait_seen_unused_q <= 1'b1;
    end
  end

  assign cfg_drop   = drop_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign pcpi_valid = valid_q;
  assign pcpi_insn  = insn_q;

endmodule
